// File: rtl/aes_op_sequencer.sv
// rtl/aes_op_sequencer.sv - AES SIMD lane sequencer: steps the shared S-box/MixColumns slice over the vector lanes
// Registered outputs are computed from next-state, so each output reflects the state it is asserted in.
module aes_op_sequencer #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [2:0]               op_i,
    input  logic                     flush_i,
    output logic                     lane_en_o,
    output logic [$clog2(LANES)-1:0] lane_sel_o,
    output logic                     bcast_o,
    output logic [2:0]               op_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [CNT_W-1:0]         busy_cycles_o
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [LANE_W-1:0]   lane_sel_q, lane_sel_d;
    logic                lane_en_q, lane_en_d;
    logic                bcast_q, bcast_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // SubBytes and MixColumns walk the lanes; everything else is a single broadcast cycle.
    function automatic logic op_serial(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b010);
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    assign busy_o = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_RUN);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lane_sel_d = '0;
        lane_en_d  = 1'b0;
        bcast_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        cnt_d      = (busy_o && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d   = S_RUN;
                    op_d      = op_i;
                    lane_en_d = op_legal(op_i);
                    bcast_d   = !op_serial(op_i);
                end
            end
            S_RUN: begin
                if (!op_legal(op_q)) begin
                    err_d = 1'b1;
                end
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (op_serial(op_q) && (lane_sel_q != LAST_LANE)) begin
                    lane_en_d  = 1'b1;
                    lane_sel_d = lane_sel_q + LANE_W'(1);
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 3'b000;
            lane_sel_q <= '0;
            lane_en_q  <= 1'b0;
            bcast_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lane_sel_q <= lane_sel_d;
            lane_en_q  <= lane_en_d;
            bcast_q    <= bcast_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign lane_en_o     = lane_en_q;
    assign lane_sel_o    = lane_sel_q;
    assign bcast_o       = bcast_q;
    assign op_o          = op_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign busy_cycles_o = cnt_q;

endmodule

// File: tb/tb_aes_op_sequencer.sv
// tb/tb_aes_op_sequencer.sv - self-checking bench for aes_op_sequencer (LANES=4, CNT_W=4)
module tb_aes_op_sequencer;

    localparam int LANES   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    localparam int NVEC    = 27;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [2:0] op_i;
    logic       flush_i;
    logic       lane_en_o;
    logic [1:0] lane_sel_o;
    logic       bcast_o;
    logic [2:0] op_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [3:0] busy_cycles_o;

    aes_op_sequencer #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .op_i          (op_i),
        .flush_i       (flush_i),
        .lane_en_o     (lane_en_o),
        .lane_sel_o    (lane_sel_o),
        .bcast_o       (bcast_o),
        .op_o          (op_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .busy_cycles_o (busy_cycles_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       start;
        logic       flush;
        logic [2:0] op;
        logic       le;
        logic [1:0] sel;
        logic       bc;
        logic       done;
        logic       busy;
        logic [2:0] op_o;
        logic       err;
        logic [3:0] cnt;
    } vec_t;

    vec_t tv [NVEC];

    // Reference model: an accepted op expands into its per-cycle output schedule.
    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_RUN  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       le;
        logic [1:0] sel;
        logic       bc;
        logic       ill;
    } rec_t;

    rec_t       m_cur;
    rec_t       m_pend [$];
    logic       m_err;
    int         m_cnt;
    logic [2:0] m_op;

    function automatic rec_t mk(input logic [1:0] kind, input logic le, input logic [1:0] sel,
                                input logic bc, input logic ill);
        rec_t r;
        r.kind = kind;
        r.le   = le;
        r.sel  = sel;
        r.bc   = bc;
        r.ill  = ill;
        return r;
    endfunction

    task automatic model_reset();
        m_cur = mk(K_IDLE, 1'b0, 2'd0, 1'b0, 1'b0);
        m_pend.delete();
        m_err = 1'b0;
        m_cnt = 0;
        m_op  = 3'b000;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic [2:0] op, input logic busy_exp);
        if (m_cur.kind == K_RUN && m_cur.ill) m_err = 1'b1;
        if (busy_exp && m_cnt < CNT_MAX) m_cnt++;
        if (m_cur.kind == K_IDLE && st && !fl) begin
            m_op = op;
            if (op == 3'b000 || op == 3'b010) begin
                for (int i = 0; i < LANES; i++) m_pend.push_back(mk(K_RUN, 1'b1, 2'(i), 1'b0, 1'b0));
            end else begin
                m_pend.push_back(mk(K_RUN, !op[2], 2'd0, 1'b1, op[2]));
            end
            m_pend.push_back(mk(K_DONE, 1'b0, 2'd0, 1'b0, 1'b0));
        end else if (fl) begin
            m_pend.delete();
        end
        m_cur = (m_pend.size() > 0) ? m_pend.pop_front() : mk(K_IDLE, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic fill_table();
        //         start flush op    le sel bc done busy op_o err cnt
        tv[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0};
        tv[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd1};
        tv[2]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd2};
        tv[3]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd3};
        tv[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd4};
        tv[5]  = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd5};
        tv[6]  = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd5};
        tv[7]  = '{1'b1, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd5};
        tv[8]  = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 4'd6};
        tv[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 4'd7};
        tv[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd7};
        tv[11] = '{1'b1, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 4'd7};
        tv[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd8};
        tv[13] = '{1'b0, 1'b1, 3'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd9};
        tv[14] = '{1'b1, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd10};
        tv[15] = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 4'd11};
        tv[16] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 4'd12};
        tv[17] = '{1'b1, 1'b1, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd12};
        tv[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd12};
        tv[19] = '{1'b1, 1'b0, 3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 4'd12};
        tv[20] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 4'd13};
        tv[21] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 4'd14};
        tv[22] = '{1'b1, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 4'd14};
        tv[23] = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 4'd15};
        tv[24] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 4'd15};
        tv[25] = '{1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 4'd15};
        tv[26] = '{1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 4'd15};
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".lane_en"}, 32'(lane_en_o), 0);
        chk({tag, ".lane_sel"}, 32'(lane_sel_o), 0);
        chk({tag, ".bcast"}, 32'(bcast_o), 0);
        chk({tag, ".op"}, 32'(op_o), 0);
        chk({tag, ".busy"}, 32'(busy_o), 0);
        chk({tag, ".done"}, 32'(done_o), 0);
        chk({tag, ".err"}, 32'(err_o), 0);
        chk({tag, ".cnt"}, 32'(busy_cycles_o), 0);
    endtask

    initial begin
        logic busy_exp;
        rst_n   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'b000;
        fill_table();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            start_i = tv[i].start;
            flush_i = tv[i].flush;
            op_i    = tv[i].op;
            @(negedge clk);
            chk($sformatf("vec%0d.lane_en", i), 32'(lane_en_o), 32'(tv[i].le));
            chk($sformatf("vec%0d.lane_sel", i), 32'(lane_sel_o), 32'(tv[i].sel));
            chk($sformatf("vec%0d.bcast", i), 32'(bcast_o), 32'(tv[i].bc));
            chk($sformatf("vec%0d.done", i), 32'(done_o), 32'(tv[i].done));
            chk($sformatf("vec%0d.busy", i), 32'(busy_o), 32'(tv[i].busy));
            chk($sformatf("vec%0d.op", i), 32'(op_o), 32'(tv[i].op_o));
            chk($sformatf("vec%0d.err", i), 32'(err_o), 32'(tv[i].err));
            chk($sformatf("vec%0d.cnt", i), 32'(busy_cycles_o), 32'(tv[i].cnt));
        end

        // Asynchronous reset in the middle of a SubBytes run.
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("midrun.lane_en_pre", 32'(lane_en_o), 1);
        chk("midrun.lane_sel_pre", 32'(lane_sel_o), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("post_rst%0d.busy", i), 32'(busy_o), 0);
            chk($sformatf("post_rst%0d.lane_en", i), 32'(lane_en_o), 0);
            chk($sformatf("post_rst%0d.done", i), 32'(done_o), 0);
        end

        // Randomized traffic against the schedule model.
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            start_i = 1'($urandom_range(0, 1));
            flush_i = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) op_i = 3'($urandom_range(4, 7));
            else                            op_i = 3'($urandom_range(0, 3));
            @(negedge clk);
            busy_exp = (m_cur.kind == K_RUN) || (m_cur.kind == K_IDLE && start_i && !flush_i);
            chk($sformatf("rnd%0d.lane_en", c), 32'(lane_en_o), 32'(m_cur.le));
            chk($sformatf("rnd%0d.lane_sel", c), 32'(lane_sel_o), 32'(m_cur.sel));
            chk($sformatf("rnd%0d.bcast", c), 32'(bcast_o), 32'(m_cur.bc));
            chk($sformatf("rnd%0d.done", c), 32'(done_o), 32'(m_cur.kind == K_DONE));
            chk($sformatf("rnd%0d.busy", c), 32'(busy_o), 32'(busy_exp));
            chk($sformatf("rnd%0d.op", c), 32'(op_o), 32'(m_op));
            chk($sformatf("rnd%0d.err", c), 32'(err_o), 32'(m_err));
            chk($sformatf("rnd%0d.cnt", c), 32'(busy_cycles_o), 32'(m_cnt));
            model_edge(start_i, flush_i, op_i, busy_exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
